// File: rtl/tile_seq_pkg.sv
// ---------------------------------------------------------------------------
// tile_seq_pkg
// Shared definitions for the tile sequencer:
//   state_e    - sequencer state encoding
//   ceil_div   - number of ARR-wide tiles that cover a dimension
//   rem_of     - valid rows/columns in tile 'idx' of a dimension
//   word_addr  - (outer * count + inner) * arr + word address arithmetic
// ---------------------------------------------------------------------------
package tile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR_OMEM,
    LOAD_BOTH,
    RUN,
    WAIT,
    BRANCH,
    LOAD_INPUT
  } state_e;

  // arr is a power of two, so the divide reduces to a shift in hardware.
  function automatic logic [31:0] ceil_div(input logic [31:0] x, input logic [31:0] arr);
    return (x + arr - 32'd1) / arr;
  endfunction

  // Last tile of a dimension may be partial; all earlier tiles are full.
  function automatic logic [31:0] rem_of(input logic [31:0] x, input logic [31:0] idx,
                                         input logic [31:0] arr);
    logic [31:0] left;
    left = x - idx * arr;
    return (left > arr) ? arr : left;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] outer, input logic [31:0] count,
                                            input logic [31:0] inner, input logic [31:0] arr,
                                            input logic [31:0] word);
    return (outer * count + inner) * arr + word;
  endfunction

endpackage

// File: rtl/tile_idx_cnt.sv
// ---------------------------------------------------------------------------
// tile_idx_cnt
// Nested tile index counter: t wraps fastest, then m, then n.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   clr           - force t = m = n = 0 (job start / abort)
//   adv           - step to the next tile (wraps to 0 after the last tile)
//   tt, tm, tn    - tile counts per dimension
//   t, m, n       - current tile indices
//   last          - current tile is the final tile of the job
//   t_wrap        - current t is the last t tile (next step wraps t)
// ---------------------------------------------------------------------------
module tile_idx_cnt #(
  parameter int DIM_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIM_W-1:0] tt,
  input  logic [DIM_W-1:0] tm,
  input  logic [DIM_W-1:0] tn,
  output logic [DIM_W-1:0] t,
  output logic [DIM_W-1:0] m,
  output logic [DIM_W-1:0] n,
  output logic             last,
  output logic             t_wrap
);

  logic m_wrap, n_wrap;

  assign t_wrap = (t == tt - DIM_W'(1));
  assign m_wrap = (m == tm - DIM_W'(1));
  assign n_wrap = (n == tn - DIM_W'(1));
  assign last   = t_wrap && m_wrap && n_wrap;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      t <= '0;
      m <= '0;
      n <= '0;
    end else if (adv) begin
      if (!t_wrap) begin
        t <= t + DIM_W'(1);
      end else begin
        t <= '0;
        if (!m_wrap) begin
          m <= m + DIM_W'(1);
        end else begin
          m <= '0;
          n <= n_wrap ? '0 : n + DIM_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tile_seq_ctrl
// Sequences an M x N x T matrix job over an ARR x ARR MAC array, one tile at
// a time (t fastest, then m, then n), generating RAM load strobes, addresses,
// calc enable and clear pulses.
// Ports:
//   CLK, RSTN           - clock, synchronous active-low reset
//   Start, MNT          - job request and {M,N,T}, accepted only in IDLE
//   Tile_Done           - MAC array finished the current tile (WAIT only)
//   LOAD_I, LOAD_W      - input / weight RAM read strobes
//   START_CALC          - MAC calc enable (ARR cycles per tile)
//   ACC                 - accumulate into output memory (n tile != 0)
//   ICOL, WROW          - intra-tile input column / weight row
//   ADDR_I, ADDR_W, ODST- input, weight, output word addresses
//   shamt               - zero-padding shift (ARR - rem_n) * 8
//   CLR_DP, CLR_W       - datapath / weight-buffer clear pulses
//   Busy, Done, Err     - status: not idle, job-end pulse, sticky error
// Build option: define TILE_SEQ_WDOG_EN to bound WAIT with a WD_W-bit
// watchdog that aborts the job with Err when Tile_Done never arrives.
// ---------------------------------------------------------------------------
module tile_seq_ctrl
  import tile_seq_pkg::*;
#(
  parameter int ARR   = 4,
  parameter int DIM_W = 6,
  parameter int AW    = 10,
  parameter int WD_W  = 12
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   Start,
  input  logic [3*DIM_W-1:0]     MNT,
  input  logic                   Tile_Done,
  output logic                   LOAD_I,
  output logic                   LOAD_W,
  output logic                   START_CALC,
  output logic                   ACC,
  output logic [$clog2(ARR)-1:0] ICOL,
  output logic [$clog2(ARR)-1:0] WROW,
  output logic [AW-1:0]          ADDR_I,
  output logic [AW-1:0]          ADDR_W,
  output logic [AW-1:0]          ODST,
  output logic [$clog2(ARR)+2:0] shamt,
  output logic                   CLR_DP,
  output logic                   CLR_W,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err
);

  localparam int CW  = $clog2(ARR);
  localparam int CW1 = CW + 1;
  localparam int SW  = CW + 3;

  typedef logic [WD_W-1:0] wd_t;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [DIM_W-1:0] dim_m, dim_n, dim_t;
  logic [DIM_W-1:0] tt, tm, tn, t_idx, m_idx, n_idx;
  logic [CW:0]      rem_t, rem_m, rem_n, load_len;
  logic [CW-1:0]    icnt, wcnt;
  logic             last_tile, t_wrap, dims_ok, accept, in_load;
  logic             load_done, run_done, wd_expired;

  assign dims_ok = (MNT[3*DIM_W-1 -: DIM_W] != '0) && (MNT[2*DIM_W-1 -: DIM_W] != '0)
                && (MNT[DIM_W-1:0] != '0);
  assign accept  = (state == IDLE) && Start && dims_ok;

  assign tt = DIM_W'(ceil_div(32'(dim_t), 32'(ARR)));
  assign tm = DIM_W'(ceil_div(32'(dim_m), 32'(ARR)));
  assign tn = DIM_W'(ceil_div(32'(dim_n), 32'(ARR)));

  tile_idx_cnt #(.DIM_W(DIM_W)) u_idx (
    .clk    (CLK),
    .rst_n  (RSTN),
    .clr    (accept || wd_expired),
    .adv    (state == BRANCH),
    .tt     (tt),
    .tm     (tm),
    .tn     (tn),
    .t      (t_idx),
    .m      (m_idx),
    .n      (n_idx),
    .last   (last_tile),
    .t_wrap (t_wrap)
  );

  assign rem_t = CW1'(rem_of(32'(dim_t), 32'(t_idx), 32'(ARR)));
  assign rem_m = CW1'(rem_of(32'(dim_m), 32'(m_idx), 32'(ARR)));
  assign rem_n = CW1'(rem_of(32'(dim_n), 32'(n_idx), 32'(ARR)));

  // One shared counter walks the load columns and the RUN cycles.
  assign in_load   = (state == LOAD_BOTH) || (state == LOAD_INPUT);
  assign load_len  = ((state == LOAD_BOTH) && (rem_m > rem_t)) ? rem_m : rem_t;
  assign load_done = (CW1'(cnt) + CW1'(1)) == load_len;
  assign run_done  = (cnt == CW'(ARR - 1));

`ifdef TILE_SEQ_WDOG_EN
  // wd holds the number of the current WAIT cycle, starting at 1.
  wd_t wd;
  assign wd_expired = (state == WAIT) && (wd == '1);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt   <= '0;
      dim_m <= '0;
      dim_n <= '0;
      dim_t <= '0;
      Err   <= 1'b0;
`ifdef TILE_SEQ_WDOG_EN
      wd    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            if (dims_ok) begin
              dim_m <= MNT[3*DIM_W-1 -: DIM_W];
              dim_n <= MNT[2*DIM_W-1 -: DIM_W];
              dim_t <= MNT[DIM_W-1:0];
              Err   <= 1'b0;
              state <= CLR_OMEM;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        CLR_OMEM: state <= LOAD_BOTH;
        LOAD_BOTH, LOAD_INPUT: begin
          if (load_done) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (run_done) begin
            cnt   <= '0;
            state <= WAIT;
`ifdef TILE_SEQ_WDOG_EN
            wd    <= WD_W'(1);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
`ifdef TILE_SEQ_WDOG_EN
          // Timeout wins over a Tile_Done arriving in the expiring cycle.
          if (wd_expired) begin
            Err   <= 1'b1;
            state <= IDLE;
          end else if (Tile_Done) begin
            state <= BRANCH;
          end
          wd <= wd + WD_W'(1);
`else
          if (Tile_Done) state <= BRANCH;
`endif
        end
        BRANCH: begin
          if (last_tile)   state <= IDLE;
          else if (!t_wrap) state <= LOAD_INPUT;
          else             state <= LOAD_BOTH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode only registered state/counters, so they are clean and
  // all zero in IDLE (indices are back at 0 after every job or abort).
  assign icnt = in_load ? cnt : '0;
  assign wcnt = (state == LOAD_BOTH) ? cnt : '0;

  assign Busy       = (state != IDLE);
  assign LOAD_I     = ((state == LOAD_BOTH) && (CW1'(cnt) < rem_t)) || (state == LOAD_INPUT);
  assign LOAD_W     = (state == LOAD_BOTH) && (CW1'(cnt) < rem_m);
  assign START_CALC = (state == RUN);
  assign ACC        = (n_idx != '0);
  assign ICOL       = icnt;
  assign WROW       = wcnt;
  assign Done       = (state == BRANCH) && last_tile;
  assign CLR_DP     = (state == CLR_OMEM) || (state == BRANCH) || wd_expired;
  // Weights survive a BRANCH only when the next tile is another t of the
  // same (m, n) pair.
  assign CLR_W      = (state == CLR_OMEM) || ((state == BRANCH) && t_wrap) || wd_expired;

  assign ADDR_I = AW'(word_addr(32'(n_idx), 32'(tt), 32'(t_idx), 32'(ARR), 32'(icnt)));
  assign ADDR_W = AW'(word_addr(32'(n_idx), 32'(tm), 32'(m_idx), 32'(ARR), 32'(wcnt)));
  assign ODST   = AW'(word_addr(32'(m_idx), 32'(tt), 32'(t_idx), 32'(ARR), 32'(icnt)));
  assign shamt  = Busy ? SW'((32'(ARR) - 32'(rem_n)) << 3) : '0;

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tile_seq_ctrl
// Self-checking bench for tile_seq_ctrl. For each job a reference trace of
// every output, cycle by cycle, is built from nested tile loops; the DUT is
// compared against it at each falling edge. Tile_Done and Start are also
// driven outside the states that honour them to confirm they are ignored.
// ---------------------------------------------------------------------------
module tb_tile_seq_ctrl;

  localparam int ARR   = 4;
  localparam int DIM_W = 6;
  localparam int AW    = 10;
  localparam int WD_W  = 12;

  typedef struct packed {
    logic       load_i;
    logic       load_w;
    logic       start_calc;
    logic       acc;
    logic [1:0] icol;
    logic [1:0] wrow;
    logic [9:0] addr_i;
    logic [9:0] addr_w;
    logic [9:0] odst;
    logic [4:0] shamt;
    logic       clr_dp;
    logic       clr_w;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  logic Start = 1'b0;
  logic Tile_Done = 1'b0;
  logic [3*DIM_W-1:0] MNT = '0;
  logic LOAD_I, LOAD_W, START_CALC, ACC, CLR_DP, CLR_W, Busy, Done, Err;
  logic [1:0] ICOL, WROW;
  logic [AW-1:0] ADDR_I, ADDR_W, ODST;
  logic [4:0] shamt;
  obs_t got;

  int checks = 0;
  int failures = 0;
  int job_id = 0;
  int g_tt, g_tm;
  obs_t exp_q[$];
  logic td_q[$];

  always #5 CLK = ~CLK;

  tile_seq_ctrl #(.ARR(ARR), .DIM_W(DIM_W), .AW(AW), .WD_W(WD_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .Start(Start), .MNT(MNT), .Tile_Done(Tile_Done),
    .LOAD_I(LOAD_I), .LOAD_W(LOAD_W), .START_CALC(START_CALC), .ACC(ACC),
    .ICOL(ICOL), .WROW(WROW), .ADDR_I(ADDR_I), .ADDR_W(ADDR_W), .ODST(ODST),
    .shamt(shamt), .CLR_DP(CLR_DP), .CLR_W(CLR_W), .Busy(Busy), .Done(Done), .Err(Err)
  );

  assign got = {LOAD_I, LOAD_W, START_CALC, ACC, ICOL, WROW, ADDR_I, ADDR_W, ODST,
                shamt, CLR_DP, CLR_W, Busy, Done, Err};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic int cdiv(input int x);
    return (x + ARR - 1) / ARR;
  endfunction

  function automatic int remv(input int x, input int idx);
    return (x - idx * ARR > ARR) ? ARR : x - idx * ARR;
  endfunction

  function automatic obs_t idle_obs(input logic e);
    obs_t o;
    o = '0;
    o.err = e;
    return o;
  endfunction

  // Outputs common to every busy cycle of tile (t, m, n).
  function automatic obs_t mk(input int n, input int m, input int t, input int ic,
                              input int wc, input int rn);
    obs_t o;
    o = '0;
    o.busy   = 1'b1;
    o.acc    = (n != 0);
    o.icol   = 2'(ic);
    o.wrow   = 2'(wc);
    o.addr_i = 10'((n * g_tt + t) * ARR + ic);
    o.addr_w = 10'((n * g_tm + m) * ARR + wc);
    o.odst   = 10'((m * g_tt + t) * ARR + ic);
    o.shamt  = 5'((ARR - rn) * 8);
    return o;
  endfunction

  task automatic push(input obs_t o, input logic td);
    exp_q.push_back(o);
    td_q.push_back(td);
  endtask

  function automatic logic noise_td(input bit noise);
    return noise && ($urandom_range(0, 3) == 0);
  endfunction

  // wfix > 0 fixes the WAIT length; otherwise it is random (1..6 cycles).
  task automatic build_job(input int md, input int nd, input int tdim, input int wfix,
                           input bit noise);
    int tt, tm, tn, rt, rm, rn, len, w;
    obs_t o;
    exp_q.delete();
    td_q.delete();
    tt = cdiv(tdim);
    tm = cdiv(md);
    tn = cdiv(nd);
    g_tt = tt;
    g_tm = tm;
    o = mk(0, 0, 0, 0, 0, remv(nd, 0));
    o.clr_dp = 1'b1;
    o.clr_w  = 1'b1;
    push(o, noise_td(noise));
    for (int n = 0; n < tn; n++) begin
      for (int m = 0; m < tm; m++) begin
        for (int t = 0; t < tt; t++) begin
          rt = remv(tdim, t);
          rm = remv(md, m);
          rn = remv(nd, n);
          if (t == 0) begin
            len = (rt > rm) ? rt : rm;
            for (int i = 0; i < len; i++) begin
              o = mk(n, m, t, i, i, rn);
              o.load_i = (i < rt);
              o.load_w = (i < rm);
              push(o, noise_td(noise));
            end
          end else begin
            for (int i = 0; i < rt; i++) begin
              o = mk(n, m, t, i, 0, rn);
              o.load_i = 1'b1;
              push(o, noise_td(noise));
            end
          end
          for (int i = 0; i < ARR; i++) begin
            o = mk(n, m, t, 0, 0, rn);
            o.start_calc = 1'b1;
            push(o, noise_td(noise));
          end
          w = (wfix > 0) ? wfix : int'($urandom_range(1, 6));
          for (int i = 0; i < w; i++) push(mk(n, m, t, 0, 0, rn), (i == w - 1));
          o = mk(n, m, t, 0, 0, rn);
          o.clr_dp = 1'b1;
          o.clr_w  = (t == tt - 1);
          o.done   = (n == tn - 1) && (m == tm - 1) && (t == tt - 1);
          push(o, noise_td(noise));
        end
      end
    end
  endtask

  // abort_run: pull reset (with a concurrent Start) in the first RUN cycle.
  task automatic run_job(input int md, input int nd, input int tdim, input int wfix,
                         input bit noise, input bit abort_run);
    job_id++;
    build_job(md, nd, tdim, wfix, noise);
    @(negedge CLK);
    MNT = {6'(md), 6'(nd), 6'(tdim)};
    Start = 1'b1;
    Tile_Done = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      check($sformatf("job%0d_cyc%0d", job_id, i + 1), 64'(got), 64'(exp_q[i]));
      Tile_Done = td_q[i];
      Start = noise && ($urandom_range(0, 3) == 0);
      MNT = 18'($urandom);
      if (abort_run && exp_q[i].start_calc) begin
        Start = 1'b1;
        RSTN = 1'b0;
        Tile_Done = 1'b0;
        @(negedge CLK);
        check("reset_mid_run", 64'(got), 64'(idle_obs(1'b0)));
        RSTN = 1'b1;
        Start = 1'b0;
        repeat (2) begin
          @(negedge CLK);
          check("post_reset_idle", 64'(got), 64'(idle_obs(1'b0)));
        end
        return;
      end
    end
    @(negedge CLK);
    Start = 1'b0;
    Tile_Done = 1'b0;
    check($sformatf("job%0d_end", job_id), 64'(got), 64'(idle_obs(1'b0)));
  endtask

  task automatic bad_start(input int md, input int nd, input int tdim);
    @(negedge CLK);
    MNT = {6'(md), 6'(nd), 6'(tdim)};
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    check("zero_dim_err", 64'(got), 64'(idle_obs(1'b1)));
    @(negedge CLK);
    check("zero_dim_stay_idle", 64'(got), 64'(idle_obs(1'b1)));
  endtask

`ifdef TILE_SEQ_WDOG_EN
  task automatic wdog_test();
    int wait_cycles, dones;
    logic last_clr, ended;
    wait_cycles = 0;
    dones = 0;
    last_clr = 1'b0;
    ended = 1'b0;
    @(negedge CLK);
    MNT = {6'd4, 6'd4, 6'd4};
    Start = 1'b1;
    Tile_Done = 1'b0;
    @(negedge CLK);
    Start = 1'b0;
    for (int c = 0; c < (1 << WD_W) + 64; c++) begin
      if (!Busy) begin
        ended = 1'b1;
        break;
      end
      if (Done) dones++;
      if (START_CALC) begin
        wait_cycles = 0;
      end else begin
        wait_cycles++;
        last_clr = CLR_DP & CLR_W;
      end
      @(negedge CLK);
    end
    check("wdog_ended", 64'(ended), 64'(1));
    check("wdog_wait_len", 64'(wait_cycles), 64'((1 << WD_W) - 1));
    check("wdog_clr_pulse", 64'(last_clr), 64'(1));
    check("wdog_no_done", 64'(dones), 64'(0));
    check("wdog_idle_err", 64'(got), 64'(idle_obs(1'b1)));
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL tb_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_state", 64'(got), 64'(idle_obs(1'b0)));
    RSTN = 1'b1;
    @(negedge CLK);
    check("idle_after_reset", 64'(got), 64'(idle_obs(1'b0)));

    // Single tile, Tile_Done in cycle 12.
    run_job(4, 4, 4, 3, 1'b0, 1'b0);
    // 2x2x2 tiles, full remainders.
    run_job(8, 8, 8, 2, 1'b0, 1'b0);
    // Partial tiles: rem_t 4,1  rem_m 4,2  rem_n 3.
    run_job(6, 3, 5, 0, 1'b1, 1'b0);

    // Zero dimensions raise Err; the next legal job clears it.
    bad_start(4, 0, 4);
    bad_start(0, 5, 5);
    run_job(4, 4, 4, 0, 1'b1, 1'b0);

    // Reset clears a sticky Err.
    bad_start(1, 1, 0);
    @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    check("reset_clears_err", 64'(got), 64'(idle_obs(1'b0)));
    RSTN = 1'b1;

    // Reset in RUN with a simultaneous Start, then recovery.
    run_job(8, 8, 8, 2, 1'b1, 1'b1);
    run_job(5, 7, 9, 0, 1'b1, 1'b0);

    for (int j = 0; j < 20; j++) begin
      run_job(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), 0, 1'b1, 1'b0);
    end

`ifdef TILE_SEQ_WDOG_EN
    wdog_test();
    run_job(4, 4, 4, 0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_seq_ctrl.md
TILE_SEQ_CTRL -- requirements
Module: tile_seq_ctrl

Interface
REQ-001 Parameter ARR, 4: MAC array edge (tile is ARR x ARR); power of two, 2..16.
REQ-002 Parameter DIM_W, 6: width of each of M, N, T; legal values 1..2^DIM_W-1.
REQ-003 Parameter AW, 10: width of ADDR_I, ADDR_W, ODST.
REQ-004 Parameter WD_W, 12: watchdog counter width (used only under TILE_SEQ_WDOG_EN).
REQ-005 CLK  in  1  single clock, all logic on rising edge.
REQ-006 RSTN  in  1  reset, synchronous, active-low.
REQ-007 Start  in  1  job request, sampled only in IDLE.
REQ-008 MNT  in  3*DIM_W  {M,N,T}, latched on accepted Start.
REQ-009 Tile_Done  in  1  one-cycle pulse, MAC array finished current tile.
REQ-010 LOAD_I, LOAD_W  out  1 each  input/weight RAM read strobe.
REQ-011 START_CALC  out  1  MAC array calc enable.
REQ-012 ACC  out  1  accumulate into output memory (n tile index != 0).
REQ-013 ICOL, WROW  out  clog2(ARR) each  intra-tile input column / weight row.
REQ-014 ADDR_I, ADDR_W, ODST  out  AW each  input, weight and output word addresses.
REQ-015 shamt  out  clog2(ARR)+3  zero-padding shift, (ARR-rem_n)*8.
REQ-016 CLR_DP, CLR_W  out  1 each  datapath / weight-buffer clear pulse.
REQ-017 Busy  out  1  high in every state except IDLE.
REQ-018 Done  out  1  one-cycle pulse at job end.
REQ-019 Err  out  1  sticky error flag, cleared by next accepted Start.

Function
REQ-020 Tile counts SHALL be TT=ceil(T/ARR), TM=ceil(M/ARR), TN=ceil(N/ARR); remainders rem_x = min(ARR, X - x*ARR) for current index x.
REQ-021 Tile order SHALL be t fastest, then m, then n; t,m,n reset to 0 at job start.
REQ-022 States SHALL be IDLE, CLR_OMEM, LOAD_BOTH, RUN, WAIT, BRANCH, LOAD_INPUT.
REQ-023 IDLE->CLR_OMEM on Start with all of M,N,T nonzero; Start with any zero dim SHALL set Err, stay IDLE.
REQ-024 CLR_OMEM SHALL last 1 cycle, assert CLR_DP and CLR_W, go to LOAD_BOTH.
REQ-025 LOAD_BOTH SHALL last max(rem_t,rem_m) cycles; ICnt/WCnt count 0 upward; LOAD_I high while ICnt<rem_t, LOAD_W high while WCnt<rem_m; then RUN.
REQ-026 LOAD_INPUT SHALL last rem_t cycles with LOAD_I high, LOAD_W low; then RUN.
REQ-027 RUN SHALL hold START_CALC high for exactly ARR cycles, then WAIT.
REQ-028 WAIT SHALL hold until Tile_Done, then BRANCH; Tile_Done in any other state SHALL be ignored.
REQ-029 BRANCH (1 cycle) SHALL assert CLR_DP; if last tile: Done pulse, CLR_W, go IDLE; else if t advances without wrap: go LOAD_INPUT (weights reused, CLR_W low); else: CLR_W, go LOAD_BOTH.
REQ-030 ADDR_I = (n*TT+t)*ARR+ICnt; ADDR_W = (n*TM+m)*ARR+WCnt; ODST = (m*TT+t)*ARR+ICnt; results truncated to AW bits.
REQ-031 ICOL=ICnt, WROW=WCnt; both 0 outside LOAD states.
REQ-032 Start while Busy SHALL be ignored; MNT changes after latch SHALL have no effect.
REQ-033 All strobes (LOAD_*, START_CALC, CLR_*, Done) SHALL be registered-state decodes, zero outside their states.

Reset
REQ-034 RSTN low at any clock edge, including mid-job, SHALL force IDLE, clear t,m,n, counters, M,N,T, Err; all outputs 0 next cycle.

Configuration
REQ-035 TILE_SEQ_WDOG_EN defined: WAIT counts cycles; reaching 2^WD_W-1 without Tile_Done SHALL set Err, pulse CLR_DP and CLR_W, go IDLE without Done. Undefined: no counter, WAIT unbounded, WD_W unused.

Structure
REQ-036 Package tile_seq_pkg SHALL hold state encoding and the ceil-div/remainder helper functions.
REQ-037 One sub-module tile_idx_cnt SHALL implement the t/m/n nested wrap counter with last-tile and t-wrap flags.

Verification
REQ-038 ARR=4, M=N=T=4: Start at cycle 0 -> CLR_OMEM c1, LOAD_BOTH c2-5, START_CALC c6-9, Tile_Done c12 -> BRANCH c13 with Done, CLR_W, IDLE c14.
REQ-039 M=N=T=8: 8 tiles in order (t,m,n)=000,100,010,110,001,...,111; LOAD_INPUT after odd t only; ACC=1 for last four tiles.
REQ-040 T=5, M=6, N=3: second t tile rem_t=1 -> one LOAD_I cycle; shamt=8 throughout.
REQ-041 Start with N=0 -> Err=1, Busy stays 0; next Start with legal MNT clears Err.
REQ-042 TILE_SEQ_WDOG_EN, WD_W=4: no Tile_Done -> Err after 15 WAIT cycles, IDLE, no Done.
REQ-043 RSTN low during RUN and Start pulsed while Busy -> reset wins, all outputs 0; busy-time Start ignored.
